// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch stage with an in-order fetch
// queue, stale-response discard and redirect flush.
module if_fetch_unit #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC,
  output logic [31:0] PC_Next,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]      pc_q    [DEPTH];
  logic [31:0]      instr_q [DEPTH];
  logic [DEPTH-1:0] filled_q, filled_d;
  logic [AW-1:0]    head_q, head_d;
  logic [AW-1:0]    tail_q, tail_d;
  logic [AW-1:0]    fill_q, fill_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    unfl_q, unfl_d;
  logic [CW-1:0]    disc_q, disc_d;
  logic [CW:0]      occ;
  logic             fire_req, fire_id;
  logic             rsp_drop, rsp_fill;

  assign occ = {1'b0, count_q} + {1'b0, disc_q};
  assign imem_req_addr = {PC[31:2], 2'b00};
  assign imem_req_valid = !redirect_valid
                       && (occ < (CW+1)'(DEPTH));
  assign fire_req = imem_req_valid && imem_req_ready;

  assign id_valid = !redirect_valid
                 && (count_q != '0)
                 && filled_q[head_q];
  assign fire_id  = id_valid && id_ready;
  assign id_pc    = pc_q[head_q];
  assign id_instr = instr_q[head_q];

  // A response with nothing to fill and nothing to drop is ignored
  assign rsp_drop = imem_rsp_valid && (disc_q != '0);
  assign rsp_fill = imem_rsp_valid && (disc_q == '0)
                 && (unfl_q != '0);

  always_comb begin
    PC_Next = PC;
    if (redirect_valid) begin
      PC_Next = {redirect_pc[31:2], 2'b00};
    end else if (fire_req) begin
      PC_Next = PC + 32'd4;
    end
  end

  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    fill_d   = fill_q;
    count_d  = count_q;
    unfl_d   = unfl_q;
    disc_d   = disc_q;
    filled_d = filled_q;
    if (redirect_valid) begin
      head_d   = '0;
      tail_d   = '0;
      fill_d   = '0;
      count_d  = '0;
      unfl_d   = '0;
      filled_d = '0;
      // Every unfilled request still has a response coming back
      disc_d   = disc_q + unfl_q
               - CW'(rsp_drop || rsp_fill);
    end else begin
      if (fire_req) begin
        tail_d           = tail_q + 1'b1;
        filled_d[tail_q] = 1'b0;
      end
      if (rsp_drop) begin
        disc_d = disc_q - 1'b1;
      end
      if (rsp_fill) begin
        fill_d           = fill_q + 1'b1;
        filled_d[fill_q] = 1'b1;
      end
      if (fire_id) begin
        head_d = head_q + 1'b1;
      end
      count_d = count_q + CW'(fire_req) - CW'(fire_id);
      unfl_d  = unfl_q + CW'(fire_req) - CW'(rsp_fill);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      fill_q   <= '0;
      count_q  <= '0;
      unfl_q   <= '0;
      disc_q   <= '0;
      filled_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      fill_q   <= fill_d;
      count_q  <= count_d;
      unfl_q   <= unfl_d;
      disc_q   <= disc_d;
      filled_q <= filled_d;
      if (fire_req) begin
        pc_q[tail_q] <= imem_req_addr;
      end
      if (rsp_fill && !redirect_valid) begin
        instr_q[fill_q] <= imem_rsp_data;
      end
    end
  end

endmodule
